// File: rtl/prog_loader.sv
// Moves one program slot between a latency-READ_LAT disk and instruction memory,
// one word per cycle, with a re-arm interlock on the level-sensitive load request.
module prog_loader #(
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 4,
  parameter int HD_ADDR_W    = 12,
  parameter int ROM_ADDR_W   = 10,
  parameter int SLOT_WORDS   = 300,
  parameter int DEST_BASE    = 512,
  parameter int READ_LAT     = 1,
  parameter int REARM_CYCLES = 2,
  localparam int CNT_W       = $clog2(SLOT_WORDS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      prog_index,
  input  logic                  load_flag,
  input  logic                  store_mode,
  input  logic [CNT_W-1:0]      word_count,
  output logic [HD_ADDR_W-1:0]  hd_addr,
  input  logic [DATA_W-1:0]     hd_rdata,
  output logic [DATA_W-1:0]     hd_wdata,
  output logic                  hd_we,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]     rom_rdata,
  output logic [DATA_W-1:0]     rom_wdata,
  output logic                  rom_we,
  output logic                  loading,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SUM_W = IDX_W + CNT_W + HD_ADDR_W + ROM_ADDR_W + 2;
  localparam int RA_W  = $clog2(REARM_CYCLES + 1);
  localparam logic [READ_LAT-1:0] PV_TOP = READ_LAT'(1) << (READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
  state_t state, state_nx;

  logic                  armed;
  logic [RA_W-1:0]       rearm_cnt;
  logic                  store_q;
  logic [HD_ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]      len_q, idx_q;
  logic                  done_q, error_q;
  logic [READ_LAT-1:0]   pv;
  logic [CNT_W-1:0]      pi [READ_LAT];
  logic [HD_ADDR_W-1:0]  hd_addr_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic [DATA_W-1:0]     hd_wdata_q, rom_wdata_q;

  logic [CNT_W-1:0]      req_len;
  logic [SUM_W-1:0]      req_base;
  logic                  req, reject, issue, last_write, wr;
  logic [CNT_W-1:0]      wr_idx;
  logic                  rd_hd, rd_rom;

  // Bounds are checked at full precision so an oversized base never wraps into range.
  always_comb begin
    if (word_count == '0 || word_count > CNT_W'(SLOT_WORDS)) req_len = CNT_W'(SLOT_WORDS);
    else                                                      req_len = word_count;
    req_base = SUM_W'(prog_index) * SUM_W'(SLOT_WORDS);
    reject   = ((req_base + SUM_W'(req_len)) > (SUM_W'(1) << HD_ADDR_W)) ||
               ((SUM_W'(DEST_BASE) + SUM_W'(req_len)) > (SUM_W'(1) << ROM_ADDR_W));
    req      = (state == IDLE) && load_flag && armed;
  end

  assign issue      = (state == XFER);
  assign last_write = (pv == PV_TOP);
  assign wr         = pv[READ_LAT-1];
  assign wr_idx     = pi[READ_LAT-1];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req && !reject) state_nx = XFER;
      XFER:    if (idx_q + CNT_W'(1) == len_q) state_nx = DRAIN;
      DRAIN:   if (last_write) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed     <= 1'b1;
      rearm_cnt <= '0;
      store_q   <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= (state == DRAIN) && last_write;
      error_q <= req && reject;
      if (req) begin
        armed     <= 1'b0;
        rearm_cnt <= '0;
        store_q   <= store_mode;
        base_q    <= HD_ADDR_W'(req_base);
        len_q     <= req_len;
        idx_q     <= '0;
      end else if (state == IDLE && !armed) begin
        if (load_flag) rearm_cnt <= '0;
        else if (rearm_cnt + RA_W'(1) == RA_W'(REARM_CYCLES)) begin
          armed     <= 1'b1;
          rearm_cnt <= '0;
        end else rearm_cnt <= rearm_cnt + RA_W'(1);
      end
      if (issue) idx_q <= idx_q + CNT_W'(1);
    end
  end

  // Stage READ_LAT-1 of the valid/index pipeline is the write stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int unsigned j = 0; j < READ_LAT; j++) pi[j] <= '0;
    end else begin
      pv    <= (pv << 1) | READ_LAT'(issue);
      pi[0] <= idx_q;
      for (int unsigned j = 1; j < READ_LAT; j++) pi[j] <= pi[j-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hd_addr_q   <= '0;
      rom_addr_q  <= '0;
      hd_wdata_q  <= '0;
      rom_wdata_q <= '0;
    end else begin
      hd_addr_q   <= hd_addr;
      rom_addr_q  <= rom_addr;
      hd_wdata_q  <= hd_wdata;
      rom_wdata_q <= rom_wdata;
    end
  end

  // Memory ports are driven live during read/write cycles and hold otherwise.
  always_comb begin
    rd_hd     = issue && !store_q;
    rd_rom    = issue && store_q;
    hd_we     = wr && store_q;
    rom_we    = wr && !store_q;
    hd_addr   = hd_addr_q;
    rom_addr  = rom_addr_q;
    if (rd_hd || hd_we)
      hd_addr = base_q + HD_ADDR_W'(rd_hd ? idx_q : wr_idx);
    if (rd_rom || rom_we)
      rom_addr = ROM_ADDR_W'(DEST_BASE) + ROM_ADDR_W'(rd_rom ? idx_q : wr_idx);
    hd_wdata  = hd_we  ? rom_rdata : hd_wdata_q;
    rom_wdata = rom_we ? hd_rdata  : rom_wdata_q;
  end

  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign error   = error_q;
  assign loading = busy | (load_flag & armed);

endmodule

// File: tb/tb_prog_loader.sv
// Drives two prog_loader instances (READ_LAT 1 and 3) in lockstep and checks every
// cycle of each request against an offset-arithmetic model of the transfer timeline.
module tb_prog_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  prog_index;
  logic        load_flag, store_mode;
  logic [8:0]  word_count;

  logic [11:0] a_hd_addr, b_hd_addr;
  logic [9:0]  a_rom_addr, b_rom_addr;
  logic [31:0] a_hd_rdata, a_hd_wdata, a_rom_rdata, a_rom_wdata;
  logic [31:0] b_hd_rdata, b_hd_wdata, b_rom_rdata, b_rom_wdata;
  logic        a_hd_we, a_rom_we, a_loading, a_busy, a_done, a_error;
  logic        b_hd_we, b_rom_we, b_loading, b_busy, b_done, b_error;

  int vectors = 0;
  int miscompares = 0;

  logic cur_acc, cur_store;
  int   cur_N, cur_base;

  always #5 clock = ~clock;

  prog_loader #(.READ_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .prog_index(prog_index), .load_flag(load_flag),
    .store_mode(store_mode), .word_count(word_count),
    .hd_addr(a_hd_addr), .hd_rdata(a_hd_rdata), .hd_wdata(a_hd_wdata), .hd_we(a_hd_we),
    .rom_addr(a_rom_addr), .rom_rdata(a_rom_rdata), .rom_wdata(a_rom_wdata), .rom_we(a_rom_we),
    .loading(a_loading), .busy(a_busy), .done(a_done), .error(a_error));

  prog_loader #(.READ_LAT(3)) dut_b (
    .clock(clock), .reset(reset), .prog_index(prog_index), .load_flag(load_flag),
    .store_mode(store_mode), .word_count(word_count),
    .hd_addr(b_hd_addr), .hd_rdata(b_hd_rdata), .hd_wdata(b_hd_wdata), .hd_we(b_hd_we),
    .rom_addr(b_rom_addr), .rom_rdata(b_rom_rdata), .rom_wdata(b_rom_wdata), .rom_we(b_rom_we),
    .loading(b_loading), .busy(b_busy), .done(b_done), .error(b_error));

  function automatic logic [31:0] hdfn(input logic [11:0] a);
    return ({20'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction
  function automatic logic [31:0] romfn(input logic [9:0] a);
    return ({22'h0, a} * 32'h85EBCA6B) ^ 32'h0F0F1234;
  endfunction
  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Memories return a fixed function of the address presented READ_LAT cycles earlier.
  logic [11:0] a_hdh = '0, b_hdh [3] = '{default: '0};
  logic [9:0]  a_romh = '0, b_romh [3] = '{default: '0};
  always @(posedge clock) begin
    a_hdh     <= a_hd_addr;
    a_romh    <= a_rom_addr;
    b_hdh[0]  <= b_hd_addr;  b_hdh[1]  <= b_hdh[0];  b_hdh[2]  <= b_hdh[1];
    b_romh[0] <= b_rom_addr; b_romh[1] <= b_romh[0]; b_romh[2] <= b_romh[1];
  end
  assign a_hd_rdata  = hdfn(a_hdh);
  assign a_rom_rdata = romfn(a_romh);
  assign b_hd_rdata  = hdfn(b_hdh[2]);
  assign b_rom_rdata = romfn(b_romh[2]);

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", name, d, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int L, input int d,
                             input logic busy_o, done_o, err_o, hdwe, romwe, ld_o,
                             input logic [11:0] hda, input logic [9:0] roma,
                             input logic [31:0] hdwd, romwd);
    logic [5:0] exp_c, act_c;
    int k, s_base, d_base;
    logic [31:0] exp_d;
    if (cur_acc)
      exp_c = {d <= cur_N + L, d == cur_N + L + 1, 1'b0,
               (d >= 1 + L) && (d <= cur_N + L), 1'b0, d <= cur_N + L};
    else
      exp_c = {1'b0, 1'b0, d == 1, 1'b0, 1'b0, 1'b0};
    act_c = {busy_o, done_o, err_o, cur_store ? hdwe : romwe, cur_store ? romwe : hdwe, ld_o};
    chk({tag, "_ctrl"}, d, 64'(act_c), 64'(exp_c));
    if (cur_acc) begin
      s_base = cur_store ? 512 : cur_base;
      d_base = cur_store ? cur_base : 512;
      k = imin(d - 1, cur_N - 1);
      chk({tag, "_src_addr"}, d, cur_store ? 64'(roma) : 64'(hda), 64'(s_base + k));
      if (d >= 1 + L) begin
        k = imin(d - 1 - L, cur_N - 1);
        exp_d = cur_store ? romfn(10'(512 + k)) : hdfn(12'(cur_base + k));
        chk({tag, "_dst_addr"}, d, cur_store ? 64'(hda) : 64'(roma), 64'(d_base + k));
        chk({tag, "_wdata"}, d, cur_store ? 64'(hdwd) : 64'(romwd), 64'(exp_d));
      end
    end
  endtask

  task automatic step_check(input int d);
    @(negedge clock);
    check_cycle("a", 1, d, a_busy, a_done, a_error, a_hd_we, a_rom_we, a_loading,
                a_hd_addr, a_rom_addr, a_hd_wdata, a_rom_wdata);
    check_cycle("b", 3, d, b_busy, b_done, b_error, b_hd_we, b_rom_we, b_loading,
                b_hd_addr, b_rom_addr, b_hd_wdata, b_rom_wdata);
  endtask

  task automatic start_req(input logic st, input int idx, input int wc, input logic acc, input int n);
    cur_acc = acc; cur_N = n; cur_store = st; cur_base = idx * 300;
    store_mode = st; prog_index = 4'(idx); word_count = 9'(wc); load_flag = 1'b1;
    #1;
    chk("a_req_loading", 0, 64'({a_loading, a_busy}), 64'(2'b10));
    chk("b_req_loading", 0, 64'({b_loading, b_busy}), 64'(2'b10));
  endtask

  task automatic run_req(input logic st, input int idx, input int wc, input logic hold,
                         input logic acc, input int n);
    int win;
    start_req(st, idx, wc, acc, n);
    win = acc ? n + 6 : 5;
    for (int d = 1; d <= win; d++) begin
      step_check(d);
      if (!hold) load_flag = 1'b0;
      prog_index = 4'($urandom); store_mode = 1'($urandom); word_count = 9'($urandom);
    end
  endtask

  task automatic idle_chk(input int n, input logic f);
    for (int i = 0; i < n; i++) begin
      load_flag = f;
      @(negedge clock);
      chk("a_idle", i, 64'({a_busy, a_done, a_error, a_hd_we, a_rom_we, a_loading}), 64'(0));
      chk("b_idle", i, 64'({b_busy, b_done, b_error, b_hd_we, b_rom_we, b_loading}), 64'(0));
    end
  endtask

  typedef struct {
    logic st; int idx; int wc; logic hold; logic acc; int n;
  } vec_t;

  initial begin
    vec_t tbl [9];
    int idx, wc, n, sel;
    logic st, acc;
    tbl[0] = '{1'b0,  2,   0, 1'b1, 1'b1, 300};
    tbl[1] = '{1'b1,  1,   5, 1'b0, 1'b1,   5};
    tbl[2] = '{1'b0, 14,   0, 1'b1, 1'b0,   0};
    tbl[3] = '{1'b0,  0, 400, 1'b0, 1'b1, 300};
    tbl[4] = '{1'b0, 13, 196, 1'b0, 1'b1, 196};
    tbl[5] = '{1'b0, 13, 197, 1'b0, 1'b0,   0};
    tbl[6] = '{1'b1,  3,   1, 1'b1, 1'b1,   1};
    tbl[7] = '{1'b1, 15,   0, 1'b0, 1'b0,   0};
    tbl[8] = '{1'b0, 12,   0, 1'b0, 1'b1, 300};

    reset = 1'b1; load_flag = 1'b0; store_mode = 1'b0; prog_index = '0; word_count = '0;
    @(negedge clock);
    chk("a_reset", 0, {a_hd_addr, a_rom_addr, a_hd_we, a_rom_we, a_busy, a_done, a_error, a_loading}, 64'(0));
    chk("b_reset", 0, {b_hd_addr, b_rom_addr, b_hd_we, b_rom_we, b_busy, b_done, b_error, b_loading}, 64'(0));
    chk("a_reset_wdata", 0, {a_hd_wdata, a_rom_wdata}, 64'(0));
    reset = 1'b0;
    @(negedge clock);

    for (int t = 0; t < 9; t++) begin
      run_req(tbl[t].st, tbl[t].idx, tbl[t].wc, tbl[t].hold, tbl[t].acc, tbl[t].n);
      idle_chk(3, 1'b0);
    end

    // Re-arm interlock after a transfer with the request held high.
    run_req(1'b0, 4, 20, 1'b1, 1'b1, 20);
    idle_chk(3, 1'b1);
    idle_chk(1, 1'b0);
    idle_chk(4, 1'b1);
    idle_chk(2, 1'b0);
    run_req(1'b1, 5, 7, 1'b0, 1'b1, 7);
    idle_chk(3, 1'b0);

    for (int r = 0; r < 30; r++) begin
      idx = int'($urandom_range(0, 15));
      sel = int'($urandom_range(0, 3));
      wc  = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(301, 511)) : int'($urandom_range(1, 40));
      st  = 1'($urandom);
      n   = (wc == 0) ? 300 : imin(wc, 300);
      acc = (idx * 300 + n <= 4096) && (512 + n <= 1024);
      run_req(st, idx, wc, 1'($urandom), acc, n);
      idle_chk(3, 1'b0);
    end

    // Asynchronous reset in the middle of write 100 of dut_a.
    start_req(1'b0, 0, 0, 1'b1, 300);
    for (int d = 1; d <= 102; d++) begin
      step_check(d);
      load_flag = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("a_abort", 0, 64'({a_rom_we, a_busy, a_rom_addr, a_hd_addr}), 64'(0));
    chk("b_abort", 0, 64'({b_rom_we, b_busy, b_rom_addr, b_hd_addr}), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    idle_chk(3, 1'b0);
    run_req(1'b0, 0, 0, 1'b0, 1'b1, 300);
    idle_chk(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
